// File: rtl/intdiv_arb_pkg.sv
// Shared constants for the two-requester arbitrated signed divider.
package intdiv_arb_pkg;

    localparam int NREQ = 2;
    localparam int ID_W = $clog2(NREQ);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        RESP = 2'd2
    } state_t;

endpackage

// File: rtl/intdiv_intdiv.sv
// Combinational N-bit signed divider: quotient truncates toward zero,
// remainder takes the dividend's sign, results wrap to N bits.
module intdiv_intdiv #(
    parameter int N = 5
) (
    input  logic signed [N-1:0] x,
    input  logic signed [N-1:0] y,
    output logic signed [N-1:0] z,
    output logic signed [N-1:0] r
);

    // Magnitudes need N+1 bits so that |-2^(N-1)| is representable.
    logic [N:0]   ax;
    logic [N:0]   ay;
    logic [N-1:0] q;
    logic [N-1:0] m;

    always_comb begin
        ax = x[N-1] ? -{x[N-1], x} : {x[N-1], x};
        ay = y[N-1] ? -{y[N-1], y} : {y[N-1], y};
        q  = '0;
        m  = ax[N-1:0];
        if (ay != '0) begin
            q = N'(ax / ay);
            m = N'(ax % ay);
        end
        z = (x[N-1] ^ y[N-1]) ? -q : q;
        r = x[N-1] ? -m : m;
    end

endmodule

// File: rtl/intdiv_arb.sv
// Round-robin arbiter in front of a one-shot signed divider (IDLE/CALC/RESP).
// Define INTDIV_ARB_DIVZERO_EN to flag y=0 and return z=-1, r=x.
module intdiv_arb
    import intdiv_arb_pkg::*;
#(
    parameter int N = 5
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   req0_valid,
    output logic                   req0_ready,
    input  logic signed [N-1:0]    req0_x,
    input  logic signed [N-1:0]    req0_y,
    input  logic                   req1_valid,
    output logic                   req1_ready,
    input  logic signed [N-1:0]    req1_x,
    input  logic signed [N-1:0]    req1_y,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [ID_W-1:0]        rsp_id,
    output logic signed [N-1:0]    rsp_z,
    output logic signed [N-1:0]    rsp_r,
    output logic                   rsp_dz
);

    state_t            state;
    state_t            state_nxt;
    logic [ID_W-1:0]   last_grant;
    logic [ID_W-1:0]   grant_id;
    logic              accept;

    logic signed [N-1:0] op_x;
    logic signed [N-1:0] op_y;
    logic [ID_W-1:0]     op_id;

    logic signed [N-1:0] core_z;
    logic signed [N-1:0] core_r;
    logic signed [N-1:0] res_z;
    logic signed [N-1:0] res_r;
    logic                res_dz;

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        grant_id  = '0;
        case (state)
            IDLE: begin
                // On a tie the requester that lost last time wins.
                if (req0_valid && req1_valid) grant_id = ~last_grant;
                else                          grant_id = req1_valid;
                if (req0_valid || req1_valid) begin
                    accept    = 1'b1;
                    state_nxt = CALC;
                end
            end
            CALC:    state_nxt = RESP;
            RESP:    if (rsp_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign req0_ready = accept && (grant_id == 1'b0);
    assign req1_ready = accept && (grant_id == 1'b1);
    assign rsp_valid  = (state == RESP);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            last_grant <= 1'b1;
        end else begin
            state <= state_nxt;
            if (accept) last_grant <= grant_id;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_x   <= '0;
            op_y   <= '0;
            op_id  <= '0;
            rsp_id <= '0;
            rsp_z  <= '0;
            rsp_r  <= '0;
            rsp_dz <= 1'b0;
        end else begin
            if (accept) begin
                op_x  <= grant_id ? req1_x : req0_x;
                op_y  <= grant_id ? req1_y : req0_y;
                op_id <= grant_id;
            end
            if (state == CALC) begin
                rsp_id <= op_id;
                rsp_z  <= res_z;
                rsp_r  <= res_r;
                rsp_dz <= res_dz;
            end
        end
    end

    intdiv_intdiv #(.N(N)) u_core (
        .x (op_x),
        .y (op_y),
        .z (core_z),
        .r (core_r)
    );

`ifdef INTDIV_ARB_DIVZERO_EN
    assign res_dz = (op_y == '0);
    assign res_z  = res_dz ? '1   : core_z;
    assign res_r  = res_dz ? op_x : core_r;
`else
    assign res_dz = 1'b0;
    assign res_z  = core_z;
    assign res_r  = core_r;
`endif

endmodule

// File: tb/tb_intdiv_arb.sv
// Self-checking bench for intdiv_arb against an arithmetic reference model.
module tb_intdiv_arb;

    localparam int N = 5;

    logic         clk = 1'b0;
    logic         rst;
    logic         req0_valid, req1_valid;
    logic         req0_ready, req1_ready;
    logic [N-1:0] req0_x, req0_y, req1_x, req1_y;
    logic         rsp_valid, rsp_ready;
    logic         rsp_id;
    logic [N-1:0] rsp_z, rsp_r;
    logic         rsp_dz;

    int tests = 0;
    int fails = 0;

    intdiv_arb #(.N(N)) dut (
        .clk        (clk),
        .rst        (rst),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_x     (req0_x),
        .req0_y     (req0_y),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_x     (req1_x),
        .req1_y     (req1_y),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_id     (rsp_id),
        .rsp_z      (rsp_z),
        .rsp_r      (rsp_r),
        .rsp_dz     (rsp_dz)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, fails=%0d", fails);
        $fatal(1, "watchdog");
    end

    // Reference: plain integer division, then wrap to N bits.
    function automatic void ref_div(input logic [N-1:0] x, input logic [N-1:0] y,
                                    output logic [N-1:0] z, output logic [N-1:0] r,
                                    output logic dz);
        int xi, yi, q, m;
        xi = int'($signed(x));
        yi = int'($signed(y));
        dz = 1'b0;
        if (yi == 0) begin
`ifdef INTDIV_ARB_DIVZERO_EN
            dz = 1'b1;
            z  = '1;
            r  = x;
`else
            z  = '0;
            r  = x;
`endif
        end else begin
            q = xi / yi;
            m = xi - q * yi;
            z = q[N-1:0];
            r = m[N-1:0];
        end
    endfunction

    function automatic logic [2*N+1:0] ref_rsp(input logic id, input logic [N-1:0] x,
                                               input logic [N-1:0] y);
        logic [N-1:0] z, r;
        logic dz;
        ref_div(x, y, z, r, dz);
        return {id, z, r, dz};
    endfunction

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic drive_req(input int id, input logic [N-1:0] x, input logic [N-1:0] y);
        if (id == 0) begin
            req0_valid = 1'b1; req0_x = x; req0_y = y;
        end else begin
            req1_valid = 1'b1; req1_x = x; req1_y = y;
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        req0_valid = 1'b0; req1_valid = 1'b0; rsp_ready = 1'b0;
        req0_x = '0; req0_y = '0; req1_x = '0; req1_y = '0;
        @(posedge clk);
        #1;
        tests++;
        if (rsp_valid !== 1'b0) begin fails++; $display("FAIL reset_valid: got %b expected 0", rsp_valid); end
        tests++;
        if ({rsp_id, rsp_z, rsp_r, rsp_dz} !== '0) begin
            fails++; $display("FAIL reset_rsp: got %h expected 0", {rsp_id, rsp_z, rsp_r, rsp_dz});
        end
        tests++;
        if ({req1_ready, req0_ready} !== 2'b00) begin
            fails++; $display("FAIL reset_ready: got %b expected 00", {req1_ready, req0_ready});
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_arith;
        int tx [3] = '{7, -7, -16};
        int ty [3] = '{2, 2, -1};
        int ti [3] = '{0, 1, 0};
        logic [2*N+1:0] exp_v;
        logic [N-1:0] vx, vy;
        int id;
        @(posedge clk);
        #1;
        for (int i = 0; i < 13; i++) begin
            if (i < 3) begin
                vx = N'(tx[i]); vy = N'(ty[i]); id = ti[i];
            end else begin
                vx = N'($urandom); vy = N'($urandom_range(1, (1 << N) - 1)); id = int'($urandom_range(0, 1));
            end
            exp_v = ref_rsp(id[0], vx, vy);
            rsp_ready = 1'b1;
            drive_req(id, vx, vy);
            #1;
            tests++;
            if ({req1_ready, req0_ready} !== (id == 1 ? 2'b10 : 2'b01)) begin
                fails++; $display("FAIL arith_ready[%0d]: got %b for id %0d", i, {req1_ready, req0_ready}, id);
            end
            step;
            req0_valid = 1'b0; req1_valid = 1'b0;
            req0_x = N'($urandom); req0_y = N'($urandom); req1_x = N'($urandom); req1_y = N'($urandom);
            tests++;
            if (rsp_valid !== 1'b0) begin fails++; $display("FAIL arith_early[%0d]: rsp_valid got %b expected 0", i, rsp_valid); end
            step;
            tests++;
            if (rsp_valid !== 1'b1 || {rsp_id, rsp_z, rsp_r, rsp_dz} !== exp_v) begin
                fails++;
                $display("FAIL arith_rsp[%0d]: got valid=%b %h expected valid=1 %h", i, rsp_valid,
                         {rsp_id, rsp_z, rsp_r, rsp_dz}, exp_v);
            end
            step;
            tests++;
            if (rsp_valid !== 1'b0) begin fails++; $display("FAIL arith_drop[%0d]: rsp_valid got %b expected 0", i, rsp_valid); end
        end
    endtask

    task automatic test_round_robin;
        logic [2*N+1:0] q[$];
        logic [2*N+1:0] exp_v;
        logic [1:0] g, exp_g;
        int ngrant = 0, nresp = 0, last_cyc = 0;
        rst = 1'b1;
        rsp_ready = 1'b1;
        req0_valid = 1'b1; req0_x = N'($urandom); req0_y = N'($urandom_range(1, (1 << N) - 1));
        req1_valid = 1'b1; req1_x = N'($urandom); req1_y = N'($urandom_range(1, (1 << N) - 1));
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        for (int cyc = 0; cyc < 40 && (ngrant < 4 || nresp < 4); cyc++) begin
            g = {req1_ready, req0_ready};
            if (g != 2'b00 && ngrant < 4) begin
                exp_g = (ngrant % 2 == 0) ? 2'b01 : 2'b10;
                tests++;
                if (g !== exp_g) begin fails++; $display("FAIL rr_grant[%0d]: got %b expected %b", ngrant, g, exp_g); end
                if (ngrant > 0) begin
                    tests++;
                    if (cyc - last_cyc != 3) begin
                        fails++; $display("FAIL rr_spacing[%0d]: got %0d expected 3", ngrant, cyc - last_cyc);
                    end
                end
                q.push_back(g[1] ? ref_rsp(1'b1, req1_x, req1_y) : ref_rsp(1'b0, req0_x, req0_y));
                last_cyc = cyc;
                ngrant++;
            end
            if (rsp_valid === 1'b1) begin
                tests++;
                if (q.size() == 0) begin
                    fails++; $display("FAIL rr_unexpected: got rsp %h expected none", {rsp_id, rsp_z, rsp_r, rsp_dz});
                end else begin
                    exp_v = q.pop_front();
                    if ({rsp_id, rsp_z, rsp_r, rsp_dz} !== exp_v) begin
                        fails++; $display("FAIL rr_rsp[%0d]: got %h expected %h", nresp, {rsp_id, rsp_z, rsp_r, rsp_dz}, exp_v);
                    end
                end
                nresp++;
            end
            @(posedge clk);
            #1;
            if (g[0]) begin req0_x = N'($urandom); req0_y = N'($urandom_range(1, (1 << N) - 1)); end
            if (g[1]) begin req1_x = N'($urandom); req1_y = N'($urandom_range(1, (1 << N) - 1)); end
            #1;
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        tests++;
        if (ngrant < 4 || nresp < 4) begin
            fails++; $display("FAIL rr_timeout: got %0d grants %0d responses expected 4 and 4", ngrant, nresp);
        end
    endtask

    task automatic test_backpressure;
        logic [N-1:0] vx, vy;
        logic [2*N+1:0] exp_v;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
        vx = N'($urandom); vy = N'($urandom_range(1, (1 << N) - 1));
        exp_v = ref_rsp(1'b0, vx, vy);
        drive_req(0, vx, vy);
        #1;
        tests++;
        if ({req1_ready, req0_ready} !== 2'b01) begin fails++; $display("FAIL bp_accept: got %b expected 01", {req1_ready, req0_ready}); end
        step;
        req0_valid = 1'b0;
        step;
        drive_req(0, N'($urandom), N'($urandom));
        drive_req(1, N'($urandom), N'($urandom));
        #1;
        for (int k = 0; k < 5; k++) begin
            tests++;
            if (rsp_valid !== 1'b1 || {rsp_id, rsp_z, rsp_r, rsp_dz} !== exp_v || {req1_ready, req0_ready} !== 2'b00) begin
                fails++;
                $display("FAIL bp_hold[%0d]: got valid=%b rsp=%h ready=%b expected valid=1 rsp=%h ready=00", k,
                         rsp_valid, {rsp_id, rsp_z, rsp_r, rsp_dz}, {req1_ready, req0_ready}, exp_v);
            end
            @(posedge clk);
            #1;
        end
        rsp_ready = 1'b1;
        #1;
        tests++;
        if (rsp_valid !== 1'b1 || {req1_ready, req0_ready} !== 2'b00) begin
            fails++; $display("FAIL bp_release: got valid=%b ready=%b expected 1 and 00", rsp_valid, {req1_ready, req0_ready});
        end
        step;
        tests++;
        if (rsp_valid !== 1'b0 || {req1_ready, req0_ready} !== 2'b10) begin
            fails++; $display("FAIL bp_idle: got valid=%b ready=%b expected 0 and 10", rsp_valid, {req1_ready, req0_ready});
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
    endtask

    task automatic test_divzero;
        @(posedge clk);
        #1;
        rsp_ready = 1'b1;
        drive_req(0, N'(9), '0);
        step;
        req0_valid = 1'b0;
        step;
        tests++;
        if (rsp_valid !== 1'b1) begin fails++; $display("FAIL dz_valid: got %b expected 1", rsp_valid); end
`ifdef INTDIV_ARB_DIVZERO_EN
        tests++;
        if ({rsp_dz, rsp_z, rsp_r} !== {1'b1, 5'b11111, 5'd9}) begin
            fails++; $display("FAIL dz_result: got dz=%b z=%h r=%h expected dz=1 z=1f r=09", rsp_dz, rsp_z, rsp_r);
        end
`else
        tests++;
        if (rsp_dz !== 1'b0) begin fails++; $display("FAIL dz_flag: got %b expected 0", rsp_dz); end
`endif
        step;
    endtask

    task automatic test_reset_calc;
        logic [N-1:0] vx, vy;
        logic [2*N+1:0] exp_v;
        @(posedge clk);
        #1;
        rsp_ready = 1'b1;
        drive_req(0, N'(13), N'(3));
        step;
        req0_valid = 1'b0;
        rst = 1'b1;
        #1;
        tests++;
        if (rsp_valid !== 1'b0) begin fails++; $display("FAIL rc_valid: got %b expected 0", rsp_valid); end
        tests++;
        if ({rsp_id, rsp_z, rsp_r, rsp_dz} !== '0) begin
            fails++; $display("FAIL rc_clear: got %h expected 0", {rsp_id, rsp_z, rsp_r, rsp_dz});
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        vx = N'($urandom); vy = N'($urandom_range(1, (1 << N) - 1));
        exp_v = ref_rsp(1'b0, vx, vy);
        drive_req(0, vx, vy);
        drive_req(1, N'($urandom), N'($urandom_range(1, (1 << N) - 1)));
        #1;
        tests++;
        if ({req1_ready, req0_ready} !== 2'b01) begin fails++; $display("FAIL rc_tie: got %b expected 01", {req1_ready, req0_ready}); end
        step;
        req0_valid = 1'b0; req1_valid = 1'b0;
        tests++;
        if (rsp_valid !== 1'b0) begin fails++; $display("FAIL rc_stale: rsp_valid got %b expected 0", rsp_valid); end
        step;
        tests++;
        if (rsp_valid !== 1'b1 || {rsp_id, rsp_z, rsp_r, rsp_dz} !== exp_v) begin
            fails++; $display("FAIL rc_rsp: got valid=%b %h expected valid=1 %h", rsp_valid, {rsp_id, rsp_z, rsp_r, rsp_dz}, exp_v);
        end
        step;
    endtask

    initial begin
        test_reset;
        test_arith;
        test_round_robin;
        test_backpressure;
        test_divzero;
        test_reset_calc;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
